// File: rtl/thumb_fetch_aligner.sv
// rtl/thumb_fetch_aligner.sv - IF/ID fetch producer: 2-word fetch queue, Thumb halfword sequencing, redirect and discard.
module thumb_fetch_aligner #(
  parameter int               ADDR_W   = 32,
  parameter int               INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_ThumbState,
  input  logic               in_ChangePC,
  input  logic [ADDR_W-1:0]  in_ChangePCAddress,
  input  logic               in_MEMChangePC,
  input  logic [ADDR_W-1:0]  in_MEMChangePCAddress,
  output logic               out_FetchRequest,
  output logic [ADDR_W-1:0]  out_FetchAddress,
  input  logic               in_FetchValid,
  input  logic [INSTR_W-1:0] in_FetchData,
  input  logic               in_Stall,
  output logic               out_ValidInstruction_IFID,
  output logic [INSTR_W-1:0] out_PipelineRegister_IFID,
  output logic [ADDR_W-1:0]  out_AddressGoWithInstruction
);

  logic [INSTR_W-1:0] r_q_data [2];
  logic [ADDR_W-3:0]  r_q_addr [2];
  logic [1:0]         r_count;
  logic               r_head;
  logic               r_half;
  logic               r_thumb_q;
  logic               r_discard;
  logic               r_req;
  logic [ADDR_W-1:0]  r_fetch_ptr;
  logic [ADDR_W-1:0]  r_req_addr;

  logic               w_redirect;
  logic [ADDR_W-1:0]  w_target;
  logic               w_resp;
  logic               w_push;
  logic               w_accept;
  logic               w_pop;
  logic               w_tail;
  logic [1:0]         w_count_nxt;
  logic [ADDR_W-1:0]  w_fetch_ptr_nxt;
  logic               w_discard_nxt;
  logic               w_half_nxt;
  logic               w_req_nxt;
  logic [ADDR_W-1:0]  w_req_addr_nxt;
  logic               w_unused;

  assign w_redirect = in_ChangePC | in_MEMChangePC;
  assign w_target   = in_MEMChangePC ? in_MEMChangePCAddress : in_ChangePCAddress;
  assign w_resp     = r_req & in_FetchValid;
  assign w_push     = w_resp & ~r_discard & ~w_redirect;
  assign w_accept   = (r_count != 2'd0) & ~in_Stall;
  assign w_pop      = w_accept & (~in_ThumbState | r_half);
  assign w_tail     = r_head ^ r_count[0];
  assign w_unused   = &{1'b0, w_target[0]};

  always_comb begin
    w_count_nxt     = r_count;
    w_fetch_ptr_nxt = r_fetch_ptr;
    w_discard_nxt   = r_discard;
    w_half_nxt      = r_half;
    if (w_redirect) begin
      w_count_nxt     = 2'd0;
      w_fetch_ptr_nxt = {w_target[ADDR_W-1:2], 2'b00};
      // An in-flight request that has not returned must be thrown away when it does.
      w_discard_nxt   = r_req & ~in_FetchValid;
      w_half_nxt      = w_target[1] & in_ThumbState;
    end else begin
      w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
      if (w_push)
        w_fetch_ptr_nxt = r_fetch_ptr + ADDR_W'(4);
      if (w_resp)
        w_discard_nxt = 1'b0;
      if (in_ThumbState != r_thumb_q)
        w_half_nxt = 1'b0;
      else if (w_accept)
        w_half_nxt = in_ThumbState & ~r_half;
    end
    w_req_nxt      = (w_count_nxt != 2'd2) | w_discard_nxt;
    w_req_addr_nxt = (~r_req | in_FetchValid) ? w_fetch_ptr_nxt : r_req_addr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q_data    <= '{default: '0};
      r_q_addr    <= '{default: '0};
      r_count     <= 2'd0;
      r_head      <= 1'b0;
      r_half      <= 1'b0;
      r_thumb_q   <= 1'b0;
      r_discard   <= 1'b0;
      r_req       <= 1'b0;
      r_fetch_ptr <= RESET_PC;
      r_req_addr  <= RESET_PC;
    end else begin
      r_count     <= w_count_nxt;
      r_half      <= w_half_nxt;
      r_thumb_q   <= in_ThumbState;
      r_discard   <= w_discard_nxt;
      r_req       <= w_req_nxt;
      r_fetch_ptr <= w_fetch_ptr_nxt;
      r_req_addr  <= w_req_addr_nxt;
      if (w_redirect)
        r_head <= 1'b0;
      else if (w_pop)
        r_head <= ~r_head;
      if (w_push) begin
        r_q_data[w_tail] <= in_FetchData;
        r_q_addr[w_tail] <= r_req_addr[ADDR_W-1:2];
      end
    end
  end

  assign out_FetchRequest             = r_req;
  assign out_FetchAddress             = r_req_addr;
  assign out_ValidInstruction_IFID    = (r_count != 2'd0);
  assign out_PipelineRegister_IFID    = r_q_data[r_head];
  assign out_AddressGoWithInstruction = {r_q_addr[r_head], r_half & in_ThumbState, 1'b0};

endmodule

// File: tb/tb_thumb_fetch_aligner.sv
// tb/tb_thumb_fetch_aligner.sv - directed self-checking bench for thumb_fetch_aligner.
module tb_thumb_fetch_aligner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_ThumbState = 1'b0;
  logic        in_ChangePC = 1'b0;
  logic [31:0] in_ChangePCAddress = '0;
  logic        in_MEMChangePC = 1'b0;
  logic [31:0] in_MEMChangePCAddress = '0;
  logic        out_FetchRequest;
  logic [31:0] out_FetchAddress;
  logic        in_FetchValid = 1'b0;
  logic [31:0] in_FetchData = '0;
  logic        in_Stall = 1'b0;
  logic        out_ValidInstruction_IFID;
  logic [31:0] out_PipelineRegister_IFID;
  logic [31:0] out_AddressGoWithInstruction;

  int n_cmp = 0;
  int n_err = 0;
  logic mem_auto = 1'b0;

  thumb_fetch_aligner #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clock                        (clock),
    .reset                        (reset),
    .in_ThumbState                (in_ThumbState),
    .in_ChangePC                  (in_ChangePC),
    .in_ChangePCAddress           (in_ChangePCAddress),
    .in_MEMChangePC               (in_MEMChangePC),
    .in_MEMChangePCAddress        (in_MEMChangePCAddress),
    .out_FetchRequest             (out_FetchRequest),
    .out_FetchAddress             (out_FetchAddress),
    .in_FetchValid                (in_FetchValid),
    .in_FetchData                 (in_FetchData),
    .in_Stall                     (in_Stall),
    .out_ValidInstruction_IFID    (out_ValidInstruction_IFID),
    .out_PipelineRegister_IFID    (out_PipelineRegister_IFID),
    .out_AddressGoWithInstruction (out_AddressGoWithInstruction)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory answers a pending request in the same cycle when enabled.
  task automatic tick();
    in_FetchValid = mem_auto & out_FetchRequest;
    in_FetchData  = in_FetchValid ? word_at(out_FetchAddress) : 32'h0;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] data, input logic [31:0] addr);
    chk({tag, "_valid"}, 32'(out_ValidInstruction_IFID), 32'd1);
    chk({tag, "_data"}, out_PipelineRegister_IFID, data);
    chk({tag, "_addr"}, out_AddressGoWithInstruction, addr);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, 32'(out_FetchRequest), 32'd0);
    chk({tag, "_faddr"}, out_FetchAddress, 32'h0);
    chk({tag, "_valid"}, 32'(out_ValidInstruction_IFID), 32'd0);
    chk({tag, "_data"}, out_PipelineRegister_IFID, 32'h0);
    chk({tag, "_addr"}, out_AddressGoWithInstruction, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_outs("rst");

    reset = 1'b0;
    mem_auto = 1'b1;
    tick();
    chk("first_req", 32'(out_FetchRequest), 32'd1);
    chk("first_faddr", out_FetchAddress, 32'h0);
    chk("first_valid", 32'(out_ValidInstruction_IFID), 32'd0);

    for (int i = 0; i < 4; i++) begin
      tick();
      chk_head("arm", word_at(32'(4 * i)), 32'(4 * i));
    end

    in_Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", 32'(out_FetchRequest), 32'd0);
      chk_head("stall", word_at(32'hC), 32'hC);
    end
    in_Stall = 1'b0;
    tick();
    chk_head("resume0", word_at(32'h10), 32'h10);
    chk("resume_req", 32'(out_FetchRequest), 32'd1);
    chk("resume_faddr", out_FetchAddress, 32'h14);
    tick();
    chk_head("resume1", word_at(32'h14), 32'h14);

    in_Stall = 1'b1;
    tick();
    chk("full_req", 32'(out_FetchRequest), 32'd0);
    reset = 1'b1;
    tick();
    chk_reset_outs("midrst");
    reset = 1'b0;
    in_Stall = 1'b0;
    in_ThumbState = 1'b1;
    tick();
    chk("rst_req", 32'(out_FetchRequest), 32'd1);
    chk("rst_faddr", out_FetchAddress, 32'h0);

    tick();
    chk_head("th0", word_at(32'h0), 32'h0);
    tick();
    chk_head("th1", word_at(32'h0), 32'h2);
    chk("th_full_req", 32'(out_FetchRequest), 32'd0);
    tick();
    chk_head("th2", word_at(32'h4), 32'h4);
    chk("th_faddr8", out_FetchAddress, 32'h8);

    mem_auto = 1'b0;
    tick();
    chk_head("th3", word_at(32'h4), 32'h6);
    tick();
    chk("pend_valid", 32'(out_ValidInstruction_IFID), 32'd0);
    chk("pend_req", 32'(out_FetchRequest), 32'd1);
    in_ChangePC = 1'b1;
    in_ChangePCAddress = 32'h102;
    tick();
    in_ChangePC = 1'b0;
    chk("held_faddr", out_FetchAddress, 32'h8);
    chk("held_req", 32'(out_FetchRequest), 32'd1);
    mem_auto = 1'b1;
    tick();
    chk("disc_valid", 32'(out_ValidInstruction_IFID), 32'd0);
    chk("redir_faddr", out_FetchAddress, 32'h100);
    tick();
    chk_head("redir0", word_at(32'h100), 32'h102);
    tick();
    chk_head("redir1", word_at(32'h104), 32'h104);

    in_ChangePC = 1'b1;
    in_ChangePCAddress = 32'h40;
    in_MEMChangePC = 1'b1;
    in_MEMChangePCAddress = 32'h80;
    tick();
    in_ChangePC = 1'b0;
    in_MEMChangePC = 1'b0;
    chk("dual_valid", 32'(out_ValidInstruction_IFID), 32'd0);
    chk("dual_req", 32'(out_FetchRequest), 32'd1);
    chk("dual_faddr", out_FetchAddress, 32'h80);
    tick();
    chk_head("dual0", word_at(32'h80), 32'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
